// File: rtl/hh_membrane_step_if.sv
// Gating-unit link: V out to the m/h/n gating units, gate values back.
// Latency: none, wires only.
// Backpressure: the master holds gate_req and v_out until the slave raises gate_ack.
interface hh_membrane_step_if;
  logic        gate_req;
  logic [15:0] v_out;
  logic        gate_ack;
  logic [15:0] m_in;
  logic [15:0] h_in;
  logic [15:0] n_in;

  modport master (output gate_req, output v_out, input gate_ack,
                  input m_in, input h_in, input n_in);
  modport slave  (input gate_req, input v_out, output gate_ack,
                  output m_in, output h_in, output n_in);
endinterface

// File: rtl/hh_membrane_step.sv
// Hodgkin-Huxley membrane integrator: one forward-Euler step of V per accepted start.
// Latency: done pulses 12 cycles after the gate_req && gate_ack cycle.
// Backpressure: waits in REQ for gate_ack; start is ignored while busy and in the done cycle.
module hh_membrane_step #(
  parameter logic [15:0] G_NA     = 16'h7800,
  parameter logic [15:0] G_K      = 16'h2400,
  parameter logic [15:0] G_L      = 16'h004D,
  parameter logic [15:0] E_NA     = 16'h3200,
  parameter logic [15:0] E_K      = 16'hB300,
  parameter logic [15:0] E_L      = 16'hC99A,
  parameter logic [15:0] V_REST   = 16'hBF00,
  parameter logic [15:0] SPIKE_TH = 16'h0000,
  parameter int unsigned DT_SHIFT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        i_ext,
  hh_membrane_step_if.master gate,
  output logic               busy,
  output logic               done,
  output logic               spike,
  output logic [15:0]        v_mem
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CALC, S_UPD} state_t;

  localparam logic signed [33:0] V_MAX = 34'sd32767;
  localparam logic signed [33:0] V_MIN = -34'sd32768;

  state_t             state_q, state_d;
  logic [3:0]         step_q, step_d;
  logic [15:0]        v_mem_q, v_mem_d;
  logic [15:0]        i_ext_q, i_ext_d;
  logic [15:0]        m_q, m_d, h_q, h_d, n_q, n_d;
  logic [15:0]        p_q, p_d, q_q, q_d;
  logic signed [31:0] ina_q, ina_d, ik_q, ik_d, il_q, il_d;
  logic               done_q, done_d, spike_q, spike_d;

  logic signed [16:0] v_x, dv_na, dv_k, dv_l;
  logic signed [31:0] mul_a;
  logic signed [16:0] mul_b;
  logic signed [48:0] mul_p;
  logic signed [33:0] sum, sum_sh, v_sum;
  logic [15:0]        v_new;
  logic               unused_mul_bits;

  // Distance of V from each reversal potential, 17 bits so it cannot wrap
  assign v_x   = {v_mem_q[15], v_mem_q};
  assign dv_na = v_x - {E_NA[15], E_NA};
  assign dv_k  = v_x - {E_K[15], E_K};
  assign dv_l  = v_x - {E_L[15], E_L};

  // The single shared multiplier; gate operands are zero-extended (unsigned Q1.15)
  assign mul_p = 49'(mul_a) * 49'(mul_b);
  assign unused_mul_bits = ^{mul_p[48:47], mul_p[7:0]};

  // State and datapath registers; reset wins in every state and aborts a step in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= 4'd0;
      v_mem_q <= V_REST;
      i_ext_q <= 16'h0;
      m_q     <= 16'h0;
      h_q     <= 16'h0;
      n_q     <= 16'h0;
      p_q     <= 16'h0;
      q_q     <= 16'h0;
      ina_q   <= 32'sd0;
      ik_q    <= 32'sd0;
      il_q    <= 32'sd0;
      done_q  <= 1'b0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      v_mem_q <= v_mem_d;
      i_ext_q <= i_ext_d;
      m_q     <= m_d;
      h_q     <= h_d;
      n_q     <= n_d;
      p_q     <= p_d;
      q_q     <= q_d;
      ina_q   <= ina_d;
      ik_q    <= ik_d;
      il_q    <= il_d;
      done_q  <= done_d;
      spike_q <= spike_d;
    end
  end

  // Next state: IDLE -> REQ -> CALC (10 multiply steps) -> UPD -> IDLE
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: if (start && !done_q) state_d = S_REQ;
      S_REQ: begin
        if (gate.gate_ack) begin
          state_d = S_CALC;
          step_d  = 4'd1;
        end
      end
      S_CALC: begin
        step_d = step_q + 4'd1;
        if (step_q == 4'd10) state_d = S_UPD;
      end
      S_UPD:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operand select per step, capture of inputs, Euler update with saturation
  always_comb begin
    mul_a   = 32'sd0;
    mul_b   = 17'sd0;
    i_ext_d = i_ext_q;
    m_d     = m_q;
    h_d     = h_q;
    n_d     = n_q;
    p_d     = p_q;
    q_d     = q_q;
    ina_d   = ina_q;
    ik_d    = ik_q;
    il_d    = il_q;
    v_mem_d = v_mem_q;

    if (state_q == S_IDLE && start && !done_q) i_ext_d = i_ext;
    if (state_q == S_REQ && gate.gate_ack) begin
      m_d = gate.m_in;
      h_d = gate.h_in;
      n_d = gate.n_in;
    end

    case (step_q)
      4'd1:    begin mul_a = {16'h0, m_q};                mul_b = {1'b0, m_q}; end
      4'd2:    begin mul_a = {16'h0, p_q};                mul_b = {1'b0, m_q}; end
      4'd3:    begin mul_a = {16'h0, p_q};                mul_b = {1'b0, h_q}; end
      4'd4:    begin mul_a = {16'h0, n_q};                mul_b = {1'b0, n_q}; end
      4'd5:    begin mul_a = {16'h0, q_q};                mul_b = {1'b0, q_q}; end
      4'd6:    begin mul_a = {{16{G_NA[15]}}, G_NA};      mul_b = {1'b0, p_q}; end
      4'd7:    begin mul_a = ina_q;                       mul_b = dv_na;       end
      4'd8:    begin mul_a = {{16{G_K[15]}}, G_K};        mul_b = {1'b0, q_q}; end
      4'd9:    begin mul_a = ik_q;                        mul_b = dv_k;        end
      4'd10:   begin mul_a = {{16{G_L[15]}}, G_L};        mul_b = dv_l;        end
      default: begin mul_a = 32'sd0;                      mul_b = 17'sd0;      end
    endcase

    if (state_q == S_CALC) begin
      case (step_q)
        4'd1, 4'd2, 4'd3: p_d   = mul_p[30:15];
        4'd4, 4'd5:       q_d   = mul_p[30:15];
        4'd6:             ina_d = mul_p[46:15];
        4'd7:             ina_d = mul_p[39:8];
        4'd8:             ik_d  = mul_p[46:15];
        4'd9:             ik_d  = mul_p[39:8];
        4'd10:            il_d  = mul_p[39:8];
        default:          ;
      endcase
    end

    // Sum carried in 34 bits so only the final V is clamped, never a partial result
    sum    = {{18{i_ext_q[15]}}, i_ext_q} - {{2{ina_q[31]}}, ina_q}
           - {{2{ik_q[31]}}, ik_q} - {{2{il_q[31]}}, il_q};
    sum_sh = sum >>> DT_SHIFT;
    v_sum  = {{18{v_mem_q[15]}}, v_mem_q} + sum_sh;
    if (v_sum > V_MAX)      v_new = 16'h7FFF;
    else if (v_sum < V_MIN) v_new = 16'h8000;
    else                    v_new = v_sum[15:0];

    done_d  = (state_q == S_UPD);
    spike_d = (state_q == S_UPD) && ($signed(v_mem_q) < $signed(SPIKE_TH))
              && ($signed(v_new) >= $signed(SPIKE_TH));
    if (state_q == S_UPD) v_mem_d = v_new;
  end

  // Outputs: handshake and busy follow the state; V, done and spike come from flops
  always_comb begin
    gate.gate_req = (state_q == S_REQ);
    gate.v_out    = v_mem_q;
    busy          = (state_q != S_IDLE);
    done          = done_q;
    spike         = spike_q;
    v_mem         = v_mem_q;
  end

endmodule

// File: tb/tb_hh_membrane_step.sv
// Bench for hh_membrane_step: two instances (dt = 1/16 ms and dt = 1 ms) share stimulus.
// Latency: each step is checked for done exactly 12 cycles after the ack cycle.
// Backpressure: gate_ack is withheld for random cycles; gate_ack/start noise while busy.
`timescale 1ns/1ps
module tb_hh_membrane_step;

  localparam longint G_NA   = 30720;
  localparam longint G_K    = 9216;
  localparam longint G_L    = 77;
  localparam longint E_NA   = 12800;
  localparam longint E_K    = -19712;
  localparam longint E_L    = -13926;
  localparam longint V_REST = -16640;

  logic        clk = 1'b0;
  logic        reset, start, ack;
  logic [15:0] i_ext, m_drv, h_drv, n_drv;
  logic        busy4, done4, spike4, busy0, done0, spike0;
  logic [15:0] vmem4, vmem0;

  always #5 clk = ~clk;

  hh_membrane_step_if g4();
  hh_membrane_step_if g0();
  assign g4.gate_ack = ack;
  assign g4.m_in     = m_drv;
  assign g4.h_in     = h_drv;
  assign g4.n_in     = n_drv;
  assign g0.gate_ack = ack;
  assign g0.m_in     = m_drv;
  assign g0.h_in     = h_drv;
  assign g0.n_in     = n_drv;

  hh_membrane_step #(.DT_SHIFT(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .i_ext(i_ext), .gate(g4.master),
    .busy(busy4), .done(done4), .spike(spike4), .v_mem(vmem4));
  hh_membrane_step #(.DT_SHIFT(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .i_ext(i_ext), .gate(g0.master),
    .busy(busy0), .done(done0), .spike(spike0), .v_mem(vmem0));

  int     n_chk = 0;
  int     n_err = 0;
  longint mv4, mv0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sx16(input logic [15:0] x);
    return longint'($signed(x));
  endfunction

  function automatic longint t32(input longint x);
    int r;
    r = int'(x);
    return longint'(r);
  endfunction

  // Unsigned Q1.15 product, bits [30:15] kept
  function automatic longint gmul(input longint a, input longint b);
    return ((a * b) >> 15) & 64'hFFFF;
  endfunction

  // One Euler step straight from the membrane equation, in plain integer arithmetic
  function automatic longint hh_ref(input longint v, input longint iext, input longint m,
                                    input longint h, input longint n, input int dt);
    longint p, q, ina, ik, il, sum, vn;
    p   = gmul(gmul(gmul(m, m), m), h);
    q   = gmul(gmul(n, n), gmul(n, n));
    ina = t32((G_NA * p) >>> 15);
    ina = t32((ina * (v - E_NA)) >>> 8);
    ik  = t32((G_K * q) >>> 15);
    ik  = t32((ik * (v - E_K)) >>> 8);
    il  = t32((G_L * (v - E_L)) >>> 8);
    sum = iext - ina - ik - il;
    vn  = v + (sum >>> dt);
    if (vn > 32767)  vn = 32767;
    if (vn < -32768) vn = -32768;
    return vn;
  endfunction

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mv4 = V_REST; mv0 = V_REST;
  endtask

  task automatic do_step(input logic [15:0] ie, input logic [15:0] mm, input logic [15:0] hh,
                         input logic [15:0] nn, input int dly, output bit sp4);
    longint e4, e0;
    int cnt;
    @(posedge clk); #1;
    chk("done_is_pulse", done4, 0);
    start = 1'b1; i_ext = ie; ack = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; i_ext = 16'($urandom);
    chk("req_high", g4.gate_req, 1);
    chk("busy_high", busy4, 1);
    for (int k = 0; k < dly; k++) begin
      chk("v_out_hold", sx16(g4.v_out), mv4);
      @(posedge clk); #1;
      chk("req_hold", g4.gate_req, 1);
    end
    ack = 1'b1; m_drv = mm; h_drv = hh; n_drv = nn;
    @(posedge clk); #1;
    chk("req_drop", g4.gate_req, 0);
    cnt = 1;
    while (!done4 && cnt < 30) begin
      start = 1'($urandom_range(0, 1));
      ack   = 1'($urandom_range(0, 1));
      m_drv = 16'($urandom); h_drv = 16'($urandom); n_drv = 16'($urandom);
      @(posedge clk); #1;
      cnt++;
    end
    start = 1'b0; ack = 1'b0;
    chk("latency", cnt, 12);
    e4 = hh_ref(mv4, sx16(ie), longint'(mm), longint'(hh), longint'(nn), 4);
    e0 = hh_ref(mv0, sx16(ie), longint'(mm), longint'(hh), longint'(nn), 0);
    chk("done0", done0, 1);
    chk("vmem4", sx16(vmem4), e4);
    chk("vmem0", sx16(vmem0), e0);
    chk("vout4", sx16(g4.v_out), e4);
    chk("spike4", spike4, longint'(mv4 < 0 && e4 >= 0));
    chk("spike0", spike0, longint'(mv0 < 0 && e0 >= 0));
    chk("busy_clear", busy4, 0);
    sp4 = spike4;
    mv4 = e4; mv0 = e0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit sp;
    int spk_cnt, spk_exp, seen;
    longint d;
    reset = 1'b1; start = 1'b0; ack = 1'b0; i_ext = 16'h0;
    m_drv = 16'h0; h_drv = 16'h0; n_drv = 16'h0;

    // Reset state, checked while reset is still asserted
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vmem4", vmem4, 16'hBF00);
    chk("rst_vout4", g4.v_out, 16'hBF00);
    chk("rst_vmem0", vmem0, 16'hBF00);
    chk("rst_busy", busy4, 0);
    chk("rst_req", g4.gate_req, 0);
    chk("rst_done", done4, 0);
    chk("rst_spike", spike4, 0);
    reset = 1'b0;
    mv4 = V_REST; mv0 = V_REST;

    // Resting gates, small injected current
    do_step(16'h0A00, 16'h0, 16'h0, 16'h0, 0, sp);
    d = sx16(vmem4) - sx16(16'hBFD1);
    chk("t2_near_bfd1", longint'(d >= -2 && d <= 2), 1);

    // Gating units stall for 5 cycles
    do_reset();
    do_step(16'h0000, 16'h0, 16'h0, 16'h0, 5, sp);

    // Na channels fully open: V shoots up through threshold
    do_reset();
    spk_cnt = 0; spk_exp = 0;
    for (int s = 0; s < 2; s++) begin
      spk_exp += (mv4 < 0 && hh_ref(mv4, 0, 16'h7FFF, 16'h7FFF, 0, 4) >= 0) ? 1 : 0;
      do_step(16'h0000, 16'h7FFF, 16'h7FFF, 16'h0000, $urandom_range(0, 2), sp);
      spk_cnt += int'(sp);
    end
    chk("t4_spike_count", spk_cnt, spk_exp);
    chk("t4_spike_once", spk_cnt, 1);

    // Maximum current into the dt = 1 ms instance saturates V without wrapping
    do_reset();
    for (int s = 0; s < 4; s++) begin
      do_step(16'h7FFF, 16'h0, 16'h0, 16'h0, $urandom_range(0, 1), sp);
      if (s >= 2) chk("t5_sat_7fff", vmem0, 16'h7FFF);
    end

    // Reset during CALC step 5 aborts the step (V is away from rest here)
    @(posedge clk); #1;
    start = 1'b1; i_ext = 16'h0A00;
    @(posedge clk); #1;
    start = 1'b0; ack = 1'b1; m_drv = 16'h4000; h_drv = 16'h4000; n_drv = 16'h4000;
    @(posedge clk); #1;
    ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_busy4", busy4, 0);
    chk("t6_busy0", busy0, 0);
    chk("t6_vmem4", vmem4, 16'hBF00);
    chk("t6_vmem0", vmem0, 16'hBF00);
    reset = 1'b0;
    mv4 = V_REST; mv0 = V_REST;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      seen += int'(done4 | done0 | spike4 | spike0);
    end
    chk("t6_no_done", seen, 0);

    // Random steps: currents, gates and ack delays
    do_reset();
    for (int s = 0; s < 20; s++) begin
      logic [15:0] ie;
      ie = (s % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h1400));
      do_step(ie, 16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 3), sp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
